// File: rtl/lsu_mem_initiator.sv
// Load/store unit that turns core byte/half/word requests into aligned word accesses
// on a req/ready data-memory port, stalling the core and reporting bad requests.
module lsu_mem_initiator #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic [1:0]  core_err_code_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);
    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    localparam logic [CNT_W:0] TIMEOUT_W = (CNT_W+1)'(TIMEOUT);
    localparam logic [CNT_W:0] ONE_W     = (CNT_W+1)'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       size_q;
    logic [1:0]       off_q;
    logic             we_q;
    logic [1:0]       err_code_q;

    logic             illegal;
    logic             misaligned;
    logic             timeout_hit;
    logic [3:0]       be_calc;
    logic [31:0]      wd_calc;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      rd_ext;

    always_comb begin
        illegal     = (core_size_i inside {3'd3, 3'd6, 3'd7}) ||
                      (core_we_i && (core_size_i inside {3'd4, 3'd5}));
        misaligned  = ((core_size_i[1:0] == 2'd1) && core_addr_i[0]) ||
                      ((core_size_i == 3'd2) && (core_addr_i[1:0] != 2'b00));
        timeout_hit = ({1'b0, cnt_q} + ONE_W) >= TIMEOUT_W;
    end

    // Stores replicate the data across the word so the byte enables alone pick the lanes.
    always_comb begin
        be_calc = 4'b1111;
        wd_calc = '0;
        if (core_we_i) begin
            case (core_size_i[1:0])
                2'd0: begin
                    be_calc = 4'b0001 << core_addr_i[1:0];
                    wd_calc = {4{core_wd_i[7:0]}};
                end
                2'd1: begin
                    be_calc = core_addr_i[1] ? 4'b1100 : 4'b0011;
                    wd_calc = {2{core_wd_i[15:0]}};
                end
                default: wd_calc = core_wd_i;
            endcase
        end
    end

    always_comb begin
        byte_sel = mem_rd_i[{off_q, 3'b000} +: 8];
        half_sel = mem_rd_i[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            3'd0:    rd_ext = {{24{byte_sel[7]}}, byte_sel};
            3'd4:    rd_ext = {24'b0, byte_sel};
            3'd1:    rd_ext = {{16{half_sel[15]}}, half_sel};
            3'd5:    rd_ext = {16'b0, half_sel};
            default: rd_ext = mem_rd_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            size_q     <= '0;
            off_q      <= '0;
            we_q       <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (core_req_i) begin
                        if (illegal) begin
                            err_code_q <= 2'b10;
                            state_q    <= ERR;
                        end else if (misaligned) begin
                            err_code_q <= 2'b01;
                            state_q    <= ERR;
                        end else begin
                            size_q  <= core_size_i;
                            off_q   <= core_addr_i[1:0];
                            we_q    <= core_we_i;
                            cnt_q   <= '0;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ready_i) begin
                        state_q <= IDLE;
                    end else begin
                        if (cnt_q != '1)
                            cnt_q <= cnt_q + 1'b1;
                        if (timeout_hit) begin
                            err_code_q <= 2'b11;
                            state_q    <= ERR;
                        end
                    end
                end
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Core inputs are held stable while stalled, so the WAIT-phase port drive comes straight from them.
    always_comb begin
        core_rd_o       = '0;
        core_stall_o    = 1'b0;
        core_err_o      = 1'b0;
        core_err_code_o = 2'b00;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_be_o        = 4'b0000;
        mem_addr_o      = '0;
        mem_wd_o        = '0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (core_req_i) begin
                        core_stall_o = 1'b1;
                        if (!illegal && !misaligned) begin
                            mem_req_o  = 1'b1;
                            mem_we_o   = core_we_i;
                            mem_be_o   = be_calc;
                            mem_addr_o = {core_addr_i[31:2], 2'b00};
                            mem_wd_o   = wd_calc;
                        end
                    end
                end
                WAIT: begin
                    mem_req_o    = 1'b1;
                    mem_we_o     = core_we_i;
                    mem_be_o     = be_calc;
                    mem_addr_o   = {core_addr_i[31:2], 2'b00};
                    mem_wd_o     = wd_calc;
                    core_stall_o = !mem_ready_i;
                    if (mem_ready_i && !we_q)
                        core_rd_o = rd_ext;
                end
                ERR: begin
                    core_err_o      = 1'b1;
                    core_err_code_o = err_code_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: vector table driven through a scoreboard
// against a small byte-enabled memory model with programmable ready delay.
module tb_lsu_mem_initiator;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 5;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_err_o;
    logic [1:0]  core_err_code_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    always #5 clk_i = ~clk_i;

    lsu_mem_initiator #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o), .core_err_o(core_err_o), .core_err_code_o(core_err_code_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
        .mem_ready_i(mem_ready_i)
    );

    // Memory model: registered read word, ready after hold_low cycles of the access.
    logic [31:0] mem [0:63] = '{default: 32'h0};
    int          wait_cnt = 0;
    int          hold_low = 0;

    assign mem_ready_i = mem_req_o && (wait_cnt > hold_low);

    always @(posedge clk_i) begin
        if (rst_i || !mem_req_o || mem_ready_i)
            wait_cnt <= 0;
        else
            wait_cnt <= wait_cnt + 1;
        if (mem_req_o) begin
            if (mem_we_o)
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b])
                        mem[mem_addr_o[7:2]][8*b +: 8] <= mem_wd_o[8*b +: 8];
            mem_rd_i <= mem[mem_addr_o[7:2]];
        end
    end

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        int          hold;
        logic        issue;
        logic [3:0]  be;
        logic [31:0] mwd;
        logic        err;
        logic [1:0]  code;
        logic [31:0] rd;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(string name, logic we, logic [2:0] size, logic [31:0] addr,
                                logic [31:0] wd, int hold, logic issue, logic [3:0] be,
                                logic [31:0] mwd, logic err, logic [1:0] code,
                                logic [31:0] rd, int lat);
        vec_t v;
        v.name = name; v.we = we; v.size = size; v.addr = addr; v.wd = wd; v.hold = hold;
        v.issue = issue; v.be = be; v.mwd = mwd; v.err = err; v.code = code; v.rd = rd;
        v.lat = lat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkQuiet(input string name);
        checkOutput({name, ":req"},   32'(mem_req_o), 32'd0);
        checkOutput({name, ":stall"}, 32'(core_stall_o), 32'd0);
        checkOutput({name, ":err"},   32'(core_err_o), 32'd0);
        checkOutput({name, ":code"},  32'(core_err_code_o), 32'd0);
        checkOutput({name, ":rd"},    core_rd_o, 32'd0);
        checkOutput({name, ":be"},    32'(mem_be_o), 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        int   n;
        logic done;
        vec_t e;
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = v.we;
        core_size_i = v.size;
        core_addr_i = v.addr;
        core_wd_i   = v.wd;
        hold_low    = v.hold;
        sb_q.push_back(v);
        @(negedge clk_i);
        checkOutput({v.name, ":issue_stall"}, 32'(core_stall_o), 32'd1);
        checkOutput({v.name, ":issue_req"},   32'(mem_req_o), 32'(v.issue));
        checkOutput({v.name, ":issue_err"},   32'(core_err_o), 32'd0);
        checkOutput({v.name, ":issue_rd"},    core_rd_o, 32'd0);
        if (v.issue) begin
            checkOutput({v.name, ":be"},   32'(mem_be_o), 32'(v.be));
            checkOutput({v.name, ":wd"},   mem_wd_o, v.mwd);
            checkOutput({v.name, ":we"},   32'(mem_we_o), 32'(v.we));
            checkOutput({v.name, ":addr"}, mem_addr_o, {v.addr[31:2], 2'b00});
        end
        done = 1'b0;
        n    = 0;
        while (!done && n < 40) begin
            @(negedge clk_i);
            n++;
            if (!core_stall_o) done = 1'b1;
        end
        e = sb_q.pop_front();
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL %s:retire stall never released after %0d cycles", e.name, n);
        end else begin
            checkOutput({e.name, ":lat"},        32'(n), 32'(e.lat));
            checkOutput({e.name, ":err"},        32'(core_err_o), 32'(e.err));
            checkOutput({e.name, ":code"},       32'(core_err_code_o), 32'(e.code));
            checkOutput({e.name, ":rd"},         core_rd_o, e.rd);
            checkOutput({e.name, ":retire_req"}, 32'(mem_req_o), 32'(!e.err));
        end
    endtask

    initial begin
        vecs.push_back(mk("sw_word",  1, 2, 32'h10, 32'hDEADBEEF, 0, 1, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0, 1));
        vecs.push_back(mk("lw_word",  0, 2, 32'h10, 32'h0,        0, 1, 4'hF, 32'h0,        0, 0, 32'hDEADBEEF, 1));
        vecs.push_back(mk("sb_hi",    1, 0, 32'h13, 32'h123456A5, 0, 1, 4'h8, 32'hA5A5A5A5, 0, 0, 32'h0, 1));
        vecs.push_back(mk("lb_hi",    0, 0, 32'h13, 32'h0,        0, 1, 4'hF, 32'h0,        0, 0, 32'hFFFFFFA5, 1));
        vecs.push_back(mk("lbu_hi",   0, 4, 32'h13, 32'h0,        0, 1, 4'hF, 32'h0,        0, 0, 32'h000000A5, 1));
        vecs.push_back(mk("sh_hi",    1, 1, 32'h22, 32'h77778001, 0, 1, 4'hC, 32'h80018001, 0, 0, 32'h0, 1));
        vecs.push_back(mk("lh_hi",    0, 1, 32'h22, 32'h0,        0, 1, 4'hF, 32'h0,        0, 0, 32'hFFFF8001, 1));
        vecs.push_back(mk("lhu_hi",   0, 5, 32'h22, 32'h0,        0, 1, 4'hF, 32'h0,        0, 0, 32'h00008001, 1));
        vecs.push_back(mk("sw_w4",    1, 2, 32'h04, 32'h0BADF00D, 0, 1, 4'hF, 32'h0BADF00D, 0, 0, 32'h0, 1));
        vecs.push_back(mk("lw_mis",   0, 2, 32'h11, 32'h0,        0, 0, 4'h0, 32'h0,        1, 1, 32'h0, 1));
        vecs.push_back(mk("lh_mis",   0, 1, 32'h21, 32'h0,        0, 0, 4'h0, 32'h0,        1, 1, 32'h0, 1));
        vecs.push_back(mk("sz3",      0, 3, 32'h00, 32'h0,        0, 0, 4'h0, 32'h0,        1, 2, 32'h0, 1));
        vecs.push_back(mk("sbu_st",   1, 4, 32'h00, 32'h0,        0, 0, 4'h0, 32'h0,        1, 2, 32'h0, 1));
        vecs.push_back(mk("sz6_mis",  0, 6, 32'h01, 32'h0,        0, 0, 4'h0, 32'h0,        1, 2, 32'h0, 1));
        vecs.push_back(mk("lhu_mis",  0, 5, 32'h23, 32'h0,        0, 0, 4'h0, 32'h0,        1, 1, 32'h0, 1));
        vecs.push_back(mk("sh_mis",   1, 1, 32'h03, 32'h0,        0, 0, 4'h0, 32'h0,        1, 1, 32'h0, 1));
        vecs.push_back(mk("lw_tmo",   0, 2, 32'h00, 32'h0,       10, 1, 4'hF, 32'h0,        1, 3, 32'h0, TIMEOUT + 1));
        vecs.push_back(mk("lw_late",  0, 2, 32'h10, 32'h0,        1, 1, 4'hF, 32'h0,        0, 0, 32'hA5ADBEEF, 2));
        vecs.push_back(mk("lbu_b2",   0, 4, 32'h12, 32'h0,        0, 1, 4'hF, 32'h0,        0, 0, 32'h000000AD, 1));
        vecs.push_back(mk("lh_lo",    0, 1, 32'h10, 32'h0,        0, 1, 4'hF, 32'h0,        0, 0, 32'hFFFFBEEF, 1));
        vecs.push_back(mk("lhu_up",   0, 5, 32'h12, 32'h0,        0, 1, 4'hF, 32'h0,        0, 0, 32'h0000A5AD, 1));
        vecs.push_back(mk("lb_b1",    0, 0, 32'h11, 32'h0,        0, 1, 4'hF, 32'h0,        0, 0, 32'hFFFFFFBE, 1));
        vecs.push_back(mk("sb_b1",    1, 0, 32'h31, 32'h0000007F, 0, 1, 4'h2, 32'h7F7F7F7F, 0, 0, 32'h0, 1));
        vecs.push_back(mk("lb_pos",   0, 0, 32'h31, 32'h0,        0, 1, 4'hF, 32'h0,        0, 0, 32'h0000007F, 1));
        vecs.push_back(mk("sh_lo",    1, 1, 32'h20, 32'h0000ABCD, 0, 1, 4'h3, 32'hABCDABCD, 0, 0, 32'h0, 1));
        vecs.push_back(mk("lw_20",    0, 2, 32'h20, 32'h0,        2, 1, 4'hF, 32'h0,        0, 0, 32'h8001ABCD, 3));
        vecs.push_back(mk("lb_20",    0, 0, 32'h20, 32'h0,        0, 1, 4'hF, 32'h0,        0, 0, 32'hFFFFFFCD, 1));

        // Reset held with a valid request pending: every output must stay at its reset value.
        rst_i       = 1'b1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h0;
        core_wd_i   = 32'h0;
        repeat (2) @(negedge clk_i);
        checkQuiet("reset");
        @(posedge clk_i); #1;
        rst_i      = 1'b0;
        core_req_i = 1'b0;
        @(negedge clk_i);
        checkQuiet("idle");

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset in the middle of a waiting load abandons it silently.
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h4;
        hold_low    = 10;
        @(negedge clk_i);
        checkOutput("rst_wait:issue_req", 32'(mem_req_o), 32'd1);
        @(negedge clk_i);
        checkOutput("rst_wait:wait_stall", 32'(core_stall_o), 32'd1);
        checkOutput("rst_wait:wait_req",   32'(mem_req_o), 32'd1);
        @(posedge clk_i); #1;
        rst_i      = 1'b1;
        core_req_i = 1'b0;
        @(negedge clk_i);
        checkQuiet("rst_wait:during");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkQuiet("rst_wait:after");
        applyStimulus(mk("lw_after_rst", 0, 2, 32'h04, 32'h0, 0, 1, 4'hF, 32'h0, 0, 0, 32'h0BADF00D, 1));

        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        @(negedge clk_i);
        checkQuiet("final_idle");
        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit sitting between the core datapath and the external data-memory port (req/we/be/addr/wd in, registered read data and ready back).
- Acts as the initiator of that protocol: converts core load/store requests (byte/half/word, signed/unsigned) into aligned word accesses with byte enables.
- Stalls the core across the memory's one-cycle read latency and any ready wait.
- Reports misaligned, illegal-size and timeout errors instead of issuing a bad access.

Parameters:
TIMEOUT, 16, max cycles in WAIT with mem_ready_i low before a timeout error (>=1)
CNT_W, 5, width of the wait counter; must hold TIMEOUT

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous, active-high reset
core_req_i  input  1  core access request; held with all core inputs stable while core_stall_o=1
core_we_i  input  1  1=store, 0=load
core_size_i  input  3  0=B, 1=H, 2=W, 4=BU, 5=HU (stores use 0/1/2 only)
core_addr_i  input  32  byte address
core_wd_i  input  32  store data, right-aligned
core_rd_o  output  32  load result, sign/zero-extended; valid when load completes
core_stall_o  output  1  1 = hold pipeline
core_err_o  output  1  one-cycle error strobe; request retired without memory effect
core_err_code_o  output  2  01 misaligned, 10 illegal size, 11 timeout, 00 none
mem_req_o  output  1  memory request
mem_we_o  output  1  write enable
mem_be_o  output  4  byte enables
mem_addr_o  output  32  word-aligned address ({core_addr_i[31:2],2'b00})
mem_wd_o  output  32  replicated store data
mem_rd_i  input  32  registered read word (reflects request of previous cycle)
mem_ready_i  input  1  memory ready

Behaviour:
- FSM states: IDLE, WAIT, ERR. Reset -> IDLE, wait counter 0, core_err_o=0, core_err_code_o=00, mem_req_o=0, core_stall_o=0, core_rd_o=0.
- Check (combinational, in IDLE): size in {3,6,7} -> illegal (10); for legal sizes H/HU with addr[0]=1, or W with addr[1:0]!=0 -> misaligned (01). Illegal has priority over misaligned.
- IDLE, core_req_i=0: all mem outputs inactive (mem_req_o=0, mem_be_o=0), stall 0.
- IDLE, core_req_i=1, check fails: no mem_req_o; stall 1 this cycle; next state ERR.
- ERR: core_err_o=1 with code for exactly one cycle, stall 0 (request retired), -> IDLE.
- IDLE, core_req_i=1, check passes: mem_req_o=1, stall 1; capture size, addr[1:0], we; counter cleared; -> WAIT.
- WAIT: mem_req_o held 1 with same addr/we/be/wd (repeated identical writes are permitted).
  - mem_ready_i=1: stall 0, core_rd_o valid this cycle, -> IDLE.
  - mem_ready_i=0: stall 1, counter+1.
  - Counter reaching TIMEOUT -> drop mem_req_o, go to ERR with code 11.
- Min latency: 2 cycles per access (issue + complete). Back-to-back requests re-enter the IDLE issue cycle.
- Store byte enables/data:
  - SB: be=1<<addr[1:0], wd={4{wd[7:0]}}.
  - SH: be=addr[1]?1100:0011, wd={2{wd[15:0]}}.
  - SW: be=1111, wd=wd.
  - Loads: mem_we_o=0, be=1111.
- Load extract, using captured offset:
  - B/BU: byte at offset, sign/zero-extended.
  - H/HU: half at offset[1], extended.
  - W: whole word.
  - core_rd_o=0 when not completing a load.
- core_we_i=1 with size 4/5: illegal (10).
- rst_i mid-WAIT: next cycle IDLE, mem_req_o=0, pending access abandoned, no error strobe; during rst_i=1 all outputs forced to reset values.
- Counter saturates; never wraps.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> store: be=1111, 2-cycle stall pattern 1,0; load returns 0xDEADBEEF on the non-stall cycle.
- SB 0xA5 @0x13, then LB @0x13 and LBU @0x13 -> be=1000, wd=0xA5A5A5A5; LB=0xFFFFFFA5, LBU=0x000000A5.
- SH 0x8001 @0x22, then LH/LHU @0x22 -> be=1100; LH=0xFFFF8001, LHU=0x00008001.
- LW @0x11, LH @0x21, size=3 @0x0 -> no mem_req_o; one-cycle core_err_o with codes 01, 01, 10; stall released after ERR.
- Hold mem_ready_i=0 with TIMEOUT=4 -> stall 1 for issue+4 WAIT cycles, then ERR code 11; with ready at cycle 2 of WAIT instead -> normal completion, no error.
- Assert rst_i during WAIT of LW @0x4 -> next cycle mem_req_o=0, stall 0, err 0, state IDLE; subsequent LW @0x4 completes normally.
